// File: rtl/execution_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : execution_muldiv_unit                                           |
// | Brief    : RV32M multiply (single cycle) / restoring divide (32 iterations)|
// |            Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed   |
// |            overflow skip the iterations and finish one cycle after accept. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module execution_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] srcA,
    input  logic [DATA_WIDTH-1:0] srcB,
    input  logic [4:0]            rdAddr,
    input  logic                  flush,
    input  logic                  nextStall,
    output logic                  stallReq,
    output logic                  resultValid,
    output logic [DATA_WIDTH-1:0] result,
    output logic [4:0]            resultRd
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [5:0]              r_count;
    logic [DATA_WIDTH-1:0]   r_dividend;   // dividend bits shift out of MSB, quotient bits enter LSB
    logic [DATA_WIDTH-1:0]   r_divisor;
    logic [DATA_WIDTH-1:0]   r_rem;
    logic                    r_isRem;
    logic                    r_negQuo;
    logic                    r_negRem;
    logic [DATA_WIDTH-1:0]   r_result;
    logic                    r_resultValid;
    logic [4:0]              r_resultRd;

    logic                    w_isDivReq;
    logic                    w_isMulReq;
    logic                    w_acceptMul;
    logic                    w_acceptDiv;
    logic                    w_iterate;
    logic                    w_lastIter;
    logic                    w_earlyOut;

    // ---------------- multiply ----------------
    logic                    w_mulASigned;
    logic                    w_mulBSigned;
    logic [2*DATA_WIDTH-1:0] w_mulA;
    logic [2*DATA_WIDTH-1:0] w_mulB;
    logic [2*DATA_WIDTH-1:0] w_product;
    logic [DATA_WIDTH-1:0]   w_mulWord;

    assign w_mulASigned = (funct3[1:0] != 2'b11);
    assign w_mulBSigned = (funct3[1:0] == 2'b01);
    assign w_mulA       = {{DATA_WIDTH{w_mulASigned & srcA[DATA_WIDTH-1]}}, srcA};
    assign w_mulB       = {{DATA_WIDTH{w_mulBSigned & srcB[DATA_WIDTH-1]}}, srcB};
    assign w_product    = w_mulA * w_mulB;
    assign w_mulWord    = (funct3[1:0] == 2'b00) ? w_product[DATA_WIDTH-1:0]
                                                 : w_product[2*DATA_WIDTH-1:DATA_WIDTH];

    // ---------------- divide setup ----------------
    logic                    w_signedDiv;
    logic                    w_aNeg;
    logic                    w_bNeg;
    logic                    w_divZero;
    logic [DATA_WIDTH-1:0]   w_absA;
    logic [DATA_WIDTH-1:0]   w_absB;

    assign w_signedDiv = ~funct3[0];
    assign w_aNeg      = w_signedDiv & srcA[DATA_WIDTH-1];
    assign w_bNeg      = w_signedDiv & srcB[DATA_WIDTH-1];
    assign w_divZero   = (srcB == '0);
    assign w_absA      = w_aNeg ? (~srcA + 1'b1) : srcA;
    assign w_absB      = w_bNeg ? (~srcB + 1'b1) : srcB;

`ifdef MULDIV_EARLY_OUT_EN
    localparam logic [DATA_WIDTH-1:0] c_INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic                    w_overflow;
    logic [DATA_WIDTH-1:0]   w_special;

    assign w_overflow = w_signedDiv & (srcA == c_INT_MIN) & (srcB == '1);
    assign w_earlyOut = w_divZero | w_overflow;
    always_comb begin
        w_special = '0;
        if (w_divZero) begin
            w_special = funct3[1] ? srcA : '1;
        end else begin
            w_special = funct3[1] ? '0 : c_INT_MIN;
        end
    end
`else
    assign w_earlyOut = 1'b0;
`endif

    // ---------------- divide iteration ----------------
    logic [DATA_WIDTH:0]     w_shifted;
    logic                    w_qBit;
    logic [DATA_WIDTH-1:0]   w_remNext;
    logic [DATA_WIDTH-1:0]   w_quoRaw;
    logic [DATA_WIDTH-1:0]   w_quoFinal;
    logic [DATA_WIDTH-1:0]   w_remFinal;

    assign w_shifted  = {r_rem, r_dividend[DATA_WIDTH-1]};
    assign w_qBit     = (w_shifted >= {1'b0, r_divisor});
    // When no subtraction happens the shifted value is below the divisor, so its MSB is zero.
    assign w_remNext  = w_qBit ? (w_shifted[DATA_WIDTH-1:0] - r_divisor) : w_shifted[DATA_WIDTH-1:0];
    assign w_quoRaw   = {r_dividend[DATA_WIDTH-2:0], w_qBit};
    assign w_quoFinal = r_negQuo ? (~w_quoRaw + 1'b1) : w_quoRaw;
    assign w_remFinal = r_negRem ? (~w_remNext + 1'b1) : w_remNext;

    // ---------------- control ----------------
    assign w_isDivReq = reqValid & funct3[2];
    assign w_isMulReq = reqValid & ~funct3[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_acceptMul = 1'b0;
        w_acceptDiv = 1'b0;
        w_iterate   = 1'b0;
        w_lastIter  = 1'b0;
        if (flush) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_isDivReq) begin
                        w_acceptDiv = 1'b1;
                        w_stateNext = w_earlyOut ? DONE : DIV_RUN;
                    end else if (w_isMulReq && !nextStall) begin
                        w_acceptMul = 1'b1;
                    end
                end
                DIV_RUN: begin
                    w_iterate = 1'b1;
                    if (r_count == c_LAST_ITER) begin
                        w_lastIter  = 1'b1;
                        w_stateNext = DONE;
                    end
                end
                DONE: begin
                    if (!nextStall) begin
                        w_stateNext = IDLE;
                    end
                end
                default: w_stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            r_dividend    <= '0;
            r_divisor     <= '0;
            r_rem         <= '0;
            r_isRem       <= 1'b0;
            r_negQuo      <= 1'b0;
            r_negRem      <= 1'b0;
            r_result      <= '0;
            r_resultValid <= 1'b0;
            r_resultRd    <= '0;
        end else if (flush) begin
            r_resultValid <= 1'b0;
        end else if (w_acceptMul) begin
            r_result      <= w_mulWord;
            r_resultValid <= 1'b1;
            r_resultRd    <= rdAddr;
        end else if (w_acceptDiv) begin
            r_dividend    <= w_absA;
            r_divisor     <= w_absB;
            r_rem         <= '0;
            r_count       <= '0;
            r_isRem       <= funct3[1];
            // Divide-by-zero must yield all ones regardless of dividend sign.
            r_negQuo      <= (w_aNeg ^ w_bNeg) & ~w_divZero;
            r_negRem      <= w_aNeg;
            r_resultRd    <= rdAddr;
            r_resultValid <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            if (w_earlyOut) begin
                r_result      <= w_special;
                r_resultValid <= 1'b1;
            end
`endif
        end else if (w_iterate) begin
            r_rem      <= w_remNext;
            r_dividend <= w_quoRaw;
            r_count    <= r_count + 6'd1;
            if (w_lastIter) begin
                r_result      <= r_isRem ? w_remFinal : w_quoFinal;
                r_resultValid <= 1'b1;
            end
        end
    end

    assign stallReq    = ((r_state == IDLE) & w_isDivReq & ~flush) | (r_state == DIV_RUN);
    assign resultValid = r_resultValid;
    assign result      = r_result;
    assign resultRd    = r_resultRd;

endmodule
`default_nettype wire

// File: tb/tb_execution_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_execution_muldiv_unit                                        |
// | Brief    : Self-checking bench for execution_muldiv_unit; honours          |
// |            MULDIV_EARLY_OUT_EN when computing expected latencies.          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_execution_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic [2:0]  funct3;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [4:0]  rdAddr;
    logic        flush;
    logic        nextStall;
    logic        stallReq;
    logic        resultValid;
    logic [31:0] result;
    logic [4:0]  resultRd;

    int tests;
    int fails;

    execution_muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .reqValid(reqValid), .funct3(funct3),
        .srcA(srcA), .srcB(srcB), .rdAddr(rdAddr), .flush(flush),
        .nextStall(nextStall), .stallReq(stallReq), .resultValid(resultValid),
        .result(result), .resultRd(resultRd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Architectural RV32M result computed with plain integer arithmetic.
    function automatic logic [31:0] refOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        up = {32'b0, a} * {32'b0, b};
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return up[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int expLat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
        if (!f[2]) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (special) return 1;
`else
        if (special) return 33;
`endif
        return 33;
    endfunction

    function automatic int expStall(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 0;
        return expLat(f, a, b);
    endfunction

    // Presents one request at cycle T and waits (bounded) for its result; ends one cycle later.
    task automatic doOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdO,
                        output int lat, output int stl);
        int n;
        funct3 = f; srcA = a; srcB = b; rdAddr = rd; reqValid = 1'b1;
        stl = 0;
        #1;
        if (stallReq) stl++;
        tick();
        n = 1;
        while (1) begin
            if (stallReq) stl++;
            if (resultValid || n >= 100) break;
            tick();
            n++;
        end
        lat = n; res = result; rdO = resultRd;
        reqValid = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        tests++;
        if ({stallReq, resultValid, result, resultRd} !== 39'd0) begin
            fails++;
            $display("FAIL reset_outputs: got stall=%b valid=%b result=%h rd=%h required all zero",
                     stallReq, resultValid, result, resultRd);
        end
    endtask

    task automatic test_directed;
        logic [2:0]  tf[12] = '{3'd0, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd1, 3'd2, 3'd4, 3'd6};
        logic [31:0] ta[12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'd5,
                                32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                                32'hFFFFFFFB, 32'hFFFFFFFB};
        logic [31:0] tb[12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd0, 32'd0,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd2, 32'd0, 32'd0};
        logic [31:0] te[12] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'h40000000,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};
        logic [31:0] res;
        logic [4:0]  rdO;
        int          lat;
        int          stl;
        for (int i = 0; i < 12; i++) begin
            doOp(tf[i], ta[i], tb[i], 5'(i + 1), res, rdO, lat, stl);
            tests++;
            if (res !== te[i]) begin
                fails++;
                $display("FAIL directed_result[%0d]: got %h required %h", i, res, te[i]);
            end
            tests++;
            if (rdO !== 5'(i + 1)) begin
                fails++;
                $display("FAIL directed_rd[%0d]: got %0d required %0d", i, rdO, i + 1);
            end
            tests++;
            if (lat != expLat(tf[i], ta[i], tb[i])) begin
                fails++;
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, expLat(tf[i], ta[i], tb[i]));
            end
            tests++;
            if (stl != expStall(tf[i], ta[i], tb[i])) begin
                fails++;
                $display("FAIL directed_stall[%0d]: got %0d cycles required %0d", i, stl, expStall(tf[i], ta[i], tb[i]));
            end
        end
    endtask

    task automatic test_random;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [4:0]  rdO;
        int          lat;
        int          stl;
        for (int i = 0; i < 40; i++) begin
            f  = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: b = 32'hFFFFFFFF - $urandom_range(0, 9);
                default: ;
            endcase
            doOp(f, a, b, rd, res, rdO, lat, stl);
            tests++;
            if (res !== refOp(f, a, b) || rdO !== rd) begin
                fails++;
                $display("FAIL random_result f=%0d a=%h b=%h: got %h rd %0d required %h rd %0d",
                         f, a, b, res, rdO, refOp(f, a, b), rd);
            end
            tests++;
            if (lat != expLat(f, a, b) || stl != expStall(f, a, b)) begin
                fails++;
                $display("FAIL random_timing f=%0d a=%h b=%h: got lat %0d stall %0d required lat %0d stall %0d",
                         f, a, b, lat, stl, expLat(f, a, b), expStall(f, a, b));
            end
        end
    endtask

    task automatic test_next_stall;
        bit held;
        funct3 = 3'd5; srcA = 32'd100; srcB = 32'd7; rdAddr = 5'd3; reqValid = 1'b1;
        #1;
        tick();                                   // T+1
        nextStall = 1'b1;
        for (int i = 0; i < 32; i++) tick();      // T+33
        reqValid = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 3; i++) begin         // T+33..T+35
            if (!(resultValid === 1'b1 && result === 32'd14 && resultRd === 5'd3 && stallReq === 1'b0))
                held = 1'b0;
            tick();
        end
        tests++;
        if (!held) begin
            fails++;
            $display("FAIL next_stall_hold: got valid=%b result=%0d stall=%b required valid=1 result=14 stall=0",
                     resultValid, result, stallReq);
        end
        nextStall = 1'b0;                         // T+36: still DONE, new request not yet taken
        funct3 = 3'd4; srcA = 32'd1; srcB = 32'd1; reqValid = 1'b1;
        #1;
        tests++;
        if (stallReq !== 1'b0 || resultValid !== 1'b1 || result !== 32'd14) begin
            fails++;
            $display("FAIL done_release: got stall=%b valid=%b result=%0d required stall=0 valid=1 result=14",
                     stallReq, resultValid, result);
        end
        tick();                                   // T+37: IDLE takes the request
        tests++;
        if (stallReq !== 1'b1) begin
            fails++;
            $display("FAIL idle_after_done: got stall=%b required 1", stallReq);
        end
        flush = 1'b1; reqValid = 1'b0;
        tick();
        flush = 1'b0;
        funct3 = 3'd0; srcA = 32'd6; srcB = 32'd7; rdAddr = 5'd4; reqValid = 1'b1; nextStall = 1'b1;
        tick();
        tests++;
        if (result !== 32'd14 || resultValid !== 1'b0) begin
            fails++;
            $display("FAIL mul_blocked_by_nextstall: got result=%0d valid=%b required result=14 valid=0",
                     result, resultValid);
        end
        nextStall = 1'b0;
        tick();
        reqValid = 1'b0;
        tests++;
        if (result !== 32'd42 || resultValid !== 1'b1 || resultRd !== 5'd4) begin
            fails++;
            $display("FAIL mul_after_nextstall: got result=%0d valid=%b rd=%0d required 42 1 4",
                     result, resultValid, resultRd);
        end
        tick();
    endtask

    task automatic test_flush;
        bit quiet;
        funct3 = 3'd4; srcA = $urandom; srcB = $urandom | 32'd1; rdAddr = 5'd8; reqValid = 1'b1;
        #1;
        tick();                                   // T+1
        quiet = 1'b1;
        for (int i = 1; i < 10; i++) begin
            if (resultValid !== 1'b0) quiet = 1'b0;
            tick();
        end                                       // T+10
        flush = 1'b1; reqValid = 1'b0;
        tick();                                   // T+11
        flush = 1'b0;
        if (resultValid !== 1'b0) quiet = 1'b0;
        tests++;
        if (!quiet) begin
            fails++;
            $display("FAIL flush_div_no_valid: got valid=1 during flushed divide required 0");
        end
        funct3 = 3'd0; srcA = 32'd3; srcB = 32'd4; rdAddr = 5'd9; reqValid = 1'b1;
        tick();                                   // T+12
        reqValid = 1'b0;
        tests++;
        if (result !== 32'd12 || resultValid !== 1'b1 || resultRd !== 5'd9) begin
            fails++;
            $display("FAIL mul_after_flush: got result=%0d valid=%b rd=%0d required 12 1 9",
                     result, resultValid, resultRd);
        end
        funct3 = 3'd0; srcA = 32'd5; srcB = 32'd5; rdAddr = 5'd10; reqValid = 1'b1; flush = 1'b1;
        tick();
        tests++;
        if (result !== 32'd12 || resultValid !== 1'b0 || resultRd !== 5'd9) begin
            fails++;
            $display("FAIL flush_priority_mul: got result=%0d valid=%b rd=%0d required 12 0 9",
                     result, resultValid, resultRd);
        end
        funct3 = 3'd4;
        #1;
        tests++;
        if (stallReq !== 1'b0) begin
            fails++;
            $display("FAIL flush_priority_stall: got stall=%b required 0", stallReq);
        end
        tick();
        flush = 1'b0; reqValid = 1'b0;
        #1;
        tests++;
        if (stallReq !== 1'b0) begin
            fails++;
            $display("FAIL flush_priority_div: got stall=%b required 0", stallReq);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        funct3 = 3'd6; srcA = $urandom; srcB = 32'd3; rdAddr = 5'd17; reqValid = 1'b1;
        #1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1; reqValid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if ({stallReq, resultValid, result, resultRd} !== 39'd0) begin
            fails++;
            $display("FAIL reset_mid_run: got stall=%b valid=%b result=%h rd=%h required all zero",
                     stallReq, resultValid, result, resultRd);
        end
        tick();
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; reqValid = 1'b0; funct3 = 3'd0; srcA = '0; srcB = '0;
        rdAddr = '0; flush = 1'b0; nextStall = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_next_stall();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
